// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmit channel.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity bit sent after the data bits; even makes the total count of ones even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input int mode);
    logic w_xor;
    w_xor = ^data;
    case (mode)
      PARITY_ODD:  return ~w_xor;
      PARITY_EVEN: return w_xor;
      default:     return w_xor;
    endcase
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO with wrap-bit pointers, synchronous flush and a combinational head read.
module tx_byte_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic [WIDTH-1:0]      o_head,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic                w_push;
  logic                w_pop;

  // Full/empty come from registered pointers only, so a same-cycle pop never opens a push slot.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty;

  // Pointer update; flush wins over a coincident push.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else if (i_flush) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
    end else if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered UART transmitter: queues host bytes and sends them back-to-back,
// LSB first, with optional parity and one stop bit.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int TIMER_BITS      = 32,
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int DEPTH_LOG2      = 3,
  parameter int PARITY          = 0
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic [7:0]            i_data,
  output logic                  o_ready,
  input  logic                  i_flush,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam logic [TIMER_BITS-1:0] BAUD_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [TIMER_BITS-1:0] TIMER_ZERO  = {TIMER_BITS{1'b0}};
  localparam logic [TIMER_BITS-1:0] TIMER_ONE   = {{(TIMER_BITS-1){1'b0}}, 1'b1};

  tx_state_t              r_state;
  logic [TIMER_BITS-1:0]  r_timer;
  logic [2:0]             r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_busy;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_timer_zero;

  tx_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_push    (i_valid),
    .i_data    (i_data),
    .i_pop     (w_pop),
    .i_flush   (i_flush),
    .o_head    (w_head),
    .o_count   (o_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign o_ready      = !w_full;
  assign o_full       = w_full;
  assign o_empty      = w_empty;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign w_timer_zero = (r_timer == TIMER_ZERO);

  // A byte leaves the queue when idle, or at the last stop cycle to keep frames contiguous.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = !w_empty;
      ST_STOP: w_pop = w_timer_zero && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // Serializer FSM with baud timer; o_tx and o_busy are registered here.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= TIMER_ZERO;
      r_bit_idx <= 3'd0;
      r_shift   <= {DATA_BITS{1'b0}};
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else if (w_pop) begin
      r_state   <= ST_START;
      r_timer   <= BAUD_RELOAD;
      r_bit_idx <= 3'd0;
      r_shift   <= w_head;
      r_par     <= parity_bit(w_head, PARITY);
      r_tx      <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        ST_START: begin
          if (w_timer_zero) begin
            r_state   <= ST_DATA;
            r_timer   <= BAUD_RELOAD;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
        ST_DATA: begin
          if (w_timer_zero) begin
            r_timer <= BAUD_RELOAD;
            if (r_bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
        ST_PARITY: begin
          if (w_timer_zero) begin
            r_state <= ST_STOP;
            r_timer <= BAUD_RELOAD;
            r_tx    <= 1'b1;
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
        ST_STOP: begin
          if (w_timer_zero) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= TIMER_ZERO;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench: three instances (no/even/odd parity) checked every cycle
// against a frame-waveform reference model, plus directed scenarios.
module tb_uart_tx_queue;

  localparam int CPB   = 4;
  localparam int DL    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          v    [3];
  logic [7:0]    d    [3];
  logic          f    [3];
  logic          rdy  [3];
  logic          tx   [3];
  logic          busy [3];
  logic          emp  [3];
  logic          ful  [3];
  logic [DL:0]   cnt  [3];

  uart_tx_queue #(.TIMER_BITS(32), .CLOCKS_PER_BAUD(CPB), .DEPTH_LOG2(DL), .PARITY(0)) u_dut0 (
    .clk(clk), .i_reset_n(rst_n), .i_valid(v[0]), .i_data(d[0]), .o_ready(rdy[0]), .i_flush(f[0]),
    .o_tx(tx[0]), .o_busy(busy[0]), .o_empty(emp[0]), .o_full(ful[0]), .o_count(cnt[0]));
  uart_tx_queue #(.TIMER_BITS(32), .CLOCKS_PER_BAUD(CPB), .DEPTH_LOG2(DL), .PARITY(1)) u_dut1 (
    .clk(clk), .i_reset_n(rst_n), .i_valid(v[1]), .i_data(d[1]), .o_ready(rdy[1]), .i_flush(f[1]),
    .o_tx(tx[1]), .o_busy(busy[1]), .o_empty(emp[1]), .o_full(ful[1]), .o_count(cnt[1]));
  uart_tx_queue #(.TIMER_BITS(32), .CLOCKS_PER_BAUD(CPB), .DEPTH_LOG2(DL), .PARITY(2)) u_dut2 (
    .clk(clk), .i_reset_n(rst_n), .i_valid(v[2]), .i_data(d[2]), .o_ready(rdy[2]), .i_flush(f[2]),
    .o_tx(tx[2]), .o_busy(busy[2]), .o_empty(emp[2]), .o_full(ful[2]), .o_count(cnt[2]));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the waveform of the frame currently on the line.
  logic [7:0]  mq [3][DEPTH];
  int          mhead [3];
  int          mcnt  [3];
  int          mel   [3];
  int          mlen  [3];
  bit          mact  [3];
  logic [10:0] mframe [3];

  function automatic logic [10:0] build_frame(input logic [7:0] b, input int par);
    logic p;
    p = ^b;
    if (par == 2) p = ~p;
    if (par == 0) return {2'b11, b, 1'b0};
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mhead[i] = 0; mcnt[i] = 0; mel[i] = 0; mlen[i] = 10; mact[i] = 0; mframe[i] = 11'h7ff;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        for (int i = 0; i < 3; i++) begin
          int pre;
          pre = mcnt[i];
          if (mact[i]) begin
            mel[i]++;
            if (mel[i] == mlen[i] * CPB) mact[i] = 0;
          end
          if (!mact[i] && pre > 0) begin
            mframe[i] = build_frame(mq[i][mhead[i]], i);
            mlen[i]   = (i == 0) ? 10 : 11;
            mel[i]    = 0;
            mact[i]   = 1;
            mhead[i]  = (mhead[i] + 1) % DEPTH;
            mcnt[i]--;
          end
          if (f[i]) begin
            mcnt[i] = 0; mhead[i] = 0;
          end else if (v[i] && pre < DEPTH) begin
            mq[i][(mhead[i] + mcnt[i]) % DEPTH] = d[i];
            mcnt[i]++;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("tx%0d", i),    tx[i],   mact[i] ? mframe[i][mel[i] / CPB] : 1'b1);
        check_eq($sformatf("busy%0d", i),  busy[i], mact[i]);
        check_eq($sformatf("count%0d", i), cnt[i],  mcnt[i]);
        check_eq($sformatf("empty%0d", i), emp[i],  mcnt[i] == 0);
        check_eq($sformatf("full%0d", i),  ful[i],  mcnt[i] == DEPTH);
        check_eq($sformatf("ready%0d", i), rdy[i],  mcnt[i] != DEPTH);
      end
    end
  end

  task automatic push_all(input logic [7:0] b);
    for (int i = 0; i < 3; i++) begin v[i] = 1'b1; d[i] = b; end
    @(negedge clk);
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_tx%0d", tag, i),    tx[i],   1'b1);
      check_eq($sformatf("%s_busy%0d", tag, i),  busy[i], 1'b0);
      check_eq($sformatf("%s_empty%0d", tag, i), emp[i],  1'b1);
      check_eq($sformatf("%s_count%0d", tag, i), cnt[i],  0);
      check_eq($sformatf("%s_ready%0d", tag, i), rdy[i],  1'b1);
    end
  endtask

  // Counts busy cycles until every instance is idle and empty; bounded.
  task automatic run_until_idle(input string tag, input bit chk_len, input int e0, input int e1, input int e2);
    int bc [3];
    int guard;
    bit done;
    bc[0] = 0; bc[1] = 0; bc[2] = 0;
    done = 0;
    for (guard = 0; guard < 4000 && !done; guard++) begin
      for (int i = 0; i < 3; i++) if (busy[i]) bc[i]++;
      done = !busy[0] && !busy[1] && !busy[2] && emp[0] && emp[1] && emp[2];
      if (!done) @(negedge clk);
    end
    if (!done) check_eq({tag, "_timeout"}, 0, 1);
    if (chk_len) begin
      check_eq({tag, "_len0"}, bc[0], e0);
      check_eq({tag, "_len1"}, bc[1], e1);
      check_eq({tag, "_len2"}, bc[2], e2);
    end
  endtask

  initial begin
    int acc [3];
    int rate;
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; d[i] = 8'h00; f[i] = 1'b0; end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    for (int i = 0; i < 3; i++) check_eq($sformatf("rst_full%0d", i), ful[i], 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame
    push_all(8'h55);
    run_until_idle("single", 1'b1, 40, 44, 44);
    repeat (3) @(negedge clk);

    // Two back-to-back frames
    for (int i = 0; i < 3; i++) begin v[i] = 1'b1; d[i] = 8'hA5; end
    @(negedge clk);
    for (int i = 0; i < 3; i++) d[i] = 8'h3C;
    @(negedge clk);
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    run_until_idle("pair", 1'b1, 80, 88, 88);
    repeat (3) @(negedge clk);

    // Fill to full with i_valid held
    for (int i = 0; i < 3; i++) begin v[i] = 1'b1; acc[i] = 0; end
    repeat (12) begin
      for (int i = 0; i < 3; i++) begin
        d[i] = 8'($urandom);
        if (rdy[i]) acc[i]++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      check_eq($sformatf("fill_acc%0d", i),   acc[i], 9);
      check_eq($sformatf("fill_full%0d", i),  ful[i], 1'b1);
      check_eq($sformatf("fill_ready%0d", i), rdy[i], 1'b0);
    end
    run_until_idle("drain", 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Parity bit of 0x07 (bit slot 9, sampled mid-bit)
    push_all(8'h07);
    repeat (38) @(negedge clk);
    check_eq("par_none", tx[0], 1'b1);
    check_eq("par_even", tx[1], 1'b1);
    check_eq("par_odd",  tx[2], 1'b0);
    run_until_idle("parity", 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // Flush during the first frame's data bits
    for (int i = 0; i < 3; i++) v[i] = 1'b1;
    repeat (4) begin
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) v[i] = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) f[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      f[i] = 1'b0;
      check_eq($sformatf("flush_count%0d", i), cnt[i],  0);
      check_eq($sformatf("flush_busy%0d", i),  busy[i], 1'b1);
    end
    run_until_idle("flush", 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) check_eq($sformatf("flush_idle%0d", i), tx[i], 1'b1);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a frame
    push_all(8'hC3);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_all(8'h81);
    run_until_idle("after_rst", 1'b1, 40, 44, 44);

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 3000; c++) begin
      rate = ((c / 500) % 2 == 1) ? 80 : 10;
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(0, 99) < rate);
        d[i] = 8'($urandom);
        f[i] = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; f[i] = 1'b0; end
    run_until_idle("random", 1'b0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Buffered UART transmit channel: accepts bytes over a valid/ready handshake, queues them in an internal FIFO, and serializes them LSB-first as 8-bit frames with optional parity and one stop bit.
It is the outbound counterpart to the receive-and-echo path. A host writes bytes; the block drains them onto the serial line back-to-back with no idle gap.
It replaces the hand-sequenced start/done/next pulses used around the existing transmitter with a self-timed queue.

Parameters:
TIMER_BITS, 32, width of the baud timer.
CLOCKS_PER_BAUD, 868, clock cycles per bit period. Legal values are 2 and above.
DEPTH_LOG2, 3, log2 of the FIFO depth (default depth 8).
PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
clk  in  1  system clock, rising edge.
i_reset_n  in  1  asynchronous, active-low reset.
i_valid  in  1  host offers i_data.
i_data  in  8  byte to transmit.
o_ready  out  1  FIFO can accept; equals !o_full.
i_flush  in  1  synchronous clear of queued (not in-flight) bytes.
o_tx  out  1  serial line, idle high.
o_busy  out  1  a frame is on the line.
o_empty  out  1  FIFO holds no bytes.
o_full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
o_count  out  DEPTH_LOG2+1  bytes queued (in-flight byte excluded).

Behaviour:
- Reset (async, i_reset_n=0):
  - o_tx=1, o_busy=0, o_empty=1, o_full=0, o_count=0, o_ready=1.
  - FIFO pointers cleared, FSM in IDLE, baud timer cleared.
  - Applies immediately, including mid-frame; the partial frame is abandoned.
- Push: i_valid && o_ready sampled at edge k. The byte is stored and o_count increments after edge k.
  - i_valid while full is ignored; the host must hold it until o_ready.
- Pop: occurs in the cycle the FSM leaves IDLE or leaves the final STOP cycle with FIFO non-empty.
  - The head byte is loaded into the shift register at that edge.
- Simultaneous push and pop: o_count unchanged. o_ready is derived from registered full, so no push is accepted on a cycle where full=1, even if a pop happens.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1). full = MSBs differ and LSBs equal; empty = pointers equal.
- i_flush: pointers reset to equal at the next edge. The in-flight frame completes normally. If push and flush coincide, flush wins and the byte is dropped.
- FSM states and transitions:
  - IDLE: o_tx=1. If non-empty, pop → START.
  - START: o_tx=0 for CLOCKS_PER_BAUD cycles → DATA.
  - DATA: 8 bits LSB-first, each CLOCKS_PER_BAUD cycles; 3-bit bit index. After bit 7 → PARITY if PARITY≠0, else STOP.
  - PARITY: even = XOR of data bits; odd = inverted XOR. Lasts one bit period → STOP.
  - STOP: o_tx=1 for one bit period. On the last cycle: if non-empty, pop → START (zero idle cycles); else → IDLE.
- Baud timer: loads CLOCKS_PER_BAUD-1 on state/bit entry and counts down. The bit advances when the timer is 0.
- o_tx is registered, so there are no glitches.
- Latency: push at edge k into an empty FIFO with an idle FSM → o_empty=0 after k, FSM enters START at k+1, o_tx falls after edge k+1.
- Frame length: 10×CLOCKS_PER_BAUD cycles, or 11× with parity.
- o_busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - PARITY_NONE/EVEN/ODD constants
  - DATA_BITS=8
- Sub-module tx_byte_fifo:
  - Parameterized storage with async active-low reset, push/pop/flush, count/full/empty.
  - Combinational head read.
- Serializer FSM and baud timer stay in uart_tx_queue.

Test Plan:
1. CLOCKS_PER_BAUD=4, PARITY=0, push 0x55 → o_tx low after k+1, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high; o_busy high 40 cycles.
2. Push 0xA5 then 0x3C on consecutive cycles → two frames contiguous, 80 busy cycles, no idle-high cycle between frame 1's stop bit and frame 2's start bit.
3. DEPTH_LOG2=3, hold i_valid for 12 cycles → 9 bytes accepted (1 popped, 8 queued), o_full=1, o_ready=0 afterwards. Draining restores o_ready one cycle after the first subsequent pop.
4. PARITY=1 with 0x07 → parity bit 1; PARITY=2 with 0x07 → parity bit 0; both frames 44 cycles at CLOCKS_PER_BAUD=4.
5. Queue 4 bytes, assert i_flush during frame 1's DATA → frame 1 completes, o_count=0, line idle afterwards.
6. Drop i_reset_n mid-DATA → o_tx=1 and o_busy=0 immediately. After release, pushing 0x81 gives a clean frame.
